// File: rtl/drive_scheduler.sv
// rtl/drive_scheduler.sv - motor drive command sequencer with dwell, STOP bypass and IR watchdog
module drive_scheduler #(
  parameter int DWELL_CYCLES   = 2500000,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [2:0] cam_drive,
  input  logic       ir_valid,
  input  logic [7:0] ir_button,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [2:0] active_cmd,
  output logic       dwell_active
);

  localparam logic [2:0] STOP = 3'd0;
  localparam int DW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES);
  localparam logic [WW-1:0] WDOG_LOAD  = WW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_SEND, S_DWELL} state_t;

  state_t          state, next_state;
  logic [2:0]      pending;
  logic [2:0]      ir_cmd;
  logic [2:0]      ir_code;
  logic            ir_hit;
  logic [2:0]      requested;
  logic [WW-1:0]   wdog;
  logic [DW-1:0]   dwell_cnt;
  logic            latch_req;
  logic            handshake;
  logic            load_dwell;

  // Map IR remote buttons onto drive codes; unknown buttons are not hits.
  always_comb begin
    ir_hit  = 1'b1;
    ir_code = STOP;
    case (ir_button)
      8'h14:   ir_code = 3'd1;
      8'h16:   ir_code = 3'd2;
      8'h18:   ir_code = 3'd3;
      8'h11:   ir_code = 3'd4;
      8'h12:   ir_code = 3'd5;
      8'h15:   ir_code = STOP;
      default: ir_hit  = 1'b0;
    endcase
  end

  // Manual IR command with watchdog; a fresh strobe beats expiry on the same cycle.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      ir_cmd <= STOP;
      wdog   <= '0;
    end else if (mode != 2'b10) begin
      ir_cmd <= STOP;
      wdog   <= '0;
    end else if (ir_valid && ir_hit) begin
      ir_cmd <= ir_code;
      wdog   <= WDOG_LOAD;
    end else if (wdog != '0) begin
      wdog   <= wdog - 1'b1;
    end else begin
      ir_cmd <= STOP;
    end
  end

  // Requested drive code from the active mode; out-of-range camera codes mean STOP.
  always_comb begin
    requested = STOP;
    case (mode)
      2'b01:   requested = (cam_drive > 3'd5) ? STOP : cam_drive;
      2'b10:   requested = ir_cmd;
      default: requested = STOP;
    endcase
  end

  // Next-state and handshake decode for the WAIT/SEND/DWELL sequencer.
  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    handshake  = 1'b0;
    load_dwell = 1'b0;
    tx_valid   = 1'b0;
    case (state)
      S_WAIT: begin
        if (requested != active_cmd) begin
          latch_req  = 1'b1;
          next_state = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          handshake = 1'b1;
          if (pending != STOP && DWELL_CYCLES > 0) begin
            load_dwell = 1'b1;
            next_state = S_DWELL;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_DWELL: begin
        // STOP must never wait out a dwell.
        if (requested == STOP && active_cmd != STOP) begin
          latch_req  = 1'b1;
          next_state = S_SEND;
        end else if (dwell_cnt <= DW'(1)) begin
          next_state = S_WAIT;
        end
      end
      default: next_state = S_WAIT;
    endcase
  end

  // State register, pending/active command and dwell counter.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= S_WAIT;
      pending    <= STOP;
      active_cmd <= STOP;
      dwell_cnt  <= '0;
    end else begin
      state <= next_state;
      if (latch_req) pending <= requested;
      if (handshake) active_cmd <= pending;
      if (load_dwell) begin
        dwell_cnt <= DWELL_LOAD;
      end else if (state == S_DWELL) begin
        dwell_cnt <= (next_state == S_DWELL) ? dwell_cnt - 1'b1 : '0;
      end
    end
  end

  assign tx_data      = {4'hA, 1'b0, pending};
  assign dwell_active = (state == S_DWELL);

endmodule

// File: tb/tb_drive_scheduler.sv
// tb/tb_drive_scheduler.sv - scoreboard bench for drive_scheduler
module tb_drive_scheduler;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [2:0] cam_drive;
  logic       ir_valid;
  logic [7:0] ir_button;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [2:0] active_cmd;
  logic       dwell_active;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  drive_scheduler #(.DWELL_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
    .clk_50(clk_50), .reset(reset), .mode(mode), .cam_drive(cam_drive),
    .ir_valid(ir_valid), .ir_button(ir_button), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .active_cmd(active_cmd),
    .dwell_active(dwell_active)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  // Every accepted byte must match the oldest expected byte.
  always @(negedge clk_50) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_byte", exp_q.size(), 1);
      else check("sb_tx_byte", tx_data, exp_q.pop_front());
    end
  end

  initial begin
    int dlen;
    int first_t;
    int second_t;
    int lat;
    logic [2:0] hold_vals[4];
    hold_vals[0] = 3'd1; hold_vals[1] = 3'd2; hold_vals[2] = 3'd4; hold_vals[3] = 3'd5;

    reset = 1'b1; mode = 2'b00; cam_drive = 3'd0; ir_valid = 1'b0;
    ir_button = 8'h00; tx_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'hA0);
    check("rst_active", active_cmd, 0);
    check("rst_dwell", dwell_active, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_byte", tx_valid, 0);
    end

    // Camera RIGHT, then coalesce 4 and 5 during the dwell.
    mode = 2'b01; cam_drive = 3'd2; exp_q.push_back(8'hA2);
    step();
    check("cam_valid", tx_valid, 1);
    check("cam_data", tx_data, 8'hA2);
    step();
    check("cam_active", active_cmd, 2);
    check("cam_hs_drop", tx_valid, 0);
    check("cam_dwell_on", dwell_active, 1);
    dlen = 1;
    cam_drive = 3'd4;
    step();
    if (dwell_active) dlen++;
    cam_drive = 3'd5; exp_q.push_back(8'hA5);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!dwell_active) break;
      dlen++;
      check("dwell_quiet", tx_valid, 0);
    end
    check("dwell_len", dlen, 4);
    check("dwell_end_wait", tx_valid, 0);
    step();
    check("coalesce_valid", tx_valid, 1);
    check("coalesce_data", tx_data, 8'hA5);
    step();
    check("coalesce_active", active_cmd, 5);
    check("coalesce_dwell", dwell_active, 1);

    // STOP bypasses the dwell.
    cam_drive = 3'd0; exp_q.push_back(8'hA0);
    step();
    check("bypass_valid", tx_valid, 1);
    check("bypass_data", tx_data, 8'hA0);
    check("bypass_dwell_off", dwell_active, 0);
    step();
    check("bypass_active", active_cmd, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stop_no_dwell", dwell_active, 0);
      check("stop_idle", tx_valid, 0);
    end

    // IR: mode button ignored, MEDIUM accepted, watchdog expiry sends STOP.
    mode = 2'b10; ir_valid = 1'b1; ir_button = 8'h0f;
    step();
    ir_valid = 1'b0;
    repeat (3) step();
    check("ir_ignored", tx_valid, 0);
    ir_valid = 1'b1; ir_button = 8'h11;
    exp_q.push_back(8'hA4); exp_q.push_back(8'hA0);
    step();
    ir_valid = 1'b0;
    first_t = 0; second_t = 0;
    for (int t = 2; t <= 40; t++) begin
      step();
      if (t == 3) check("ir_active", active_cmd, 4);
      if (tx_valid && tx_data == 8'hA4 && first_t == 0) first_t = t;
      if (tx_valid && tx_data == 8'hA0 && second_t == 0) begin
        second_t = t;
        break;
      end
    end
    check("ir_first_lat", first_t, 2);
    check("ir_wdog_lat", second_t, 13);
    step();
    check("ir_stop_active", active_cmd, 0);

    // Back-pressure: SEND holds data stable while requests change.
    mode = 2'b01; cam_drive = 3'd3; tx_ready = 1'b0; exp_q.push_back(8'hA3);
    step();
    check("hold_valid", tx_valid, 1);
    for (int i = 0; i < 20; i++) begin
      cam_drive = hold_vals[i % 4];
      step();
      check("hold_data", tx_data, 8'hA3);
      check("hold_active", active_cmd, 0);
    end
    cam_drive = 3'd1; exp_q.push_back(8'hA1);
    tx_ready = 1'b1;
    step();
    check("release_active", active_cmd, 3);
    check("release_drop", tx_valid, 0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (tx_valid) begin
        lat = n;
        break;
      end
    end
    check("after_dwell_lat", lat, 5);
    step();
    check("left_active", active_cmd, 1);

    // Reset in the middle of SEND.
    cam_drive = 3'd2; tx_ready = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (tx_valid) begin
        lat = n;
        break;
      end
    end
    check("midsend_reached", lat != 0, 1);
    reset = 1'b1; cam_drive = 3'd6;
    step();
    check("rst_send_valid", tx_valid, 0);
    check("rst_send_active", active_cmd, 0);
    check("rst_send_dwell", dwell_active, 0);
    check("rst_send_data", tx_data, 8'hA0);
    reset = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cam6_no_byte", tx_valid, 0);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
